// File: rtl/switch_bank_sequencer_if.sv
// ---------------------------------------------------------------------------
// switch_bank_sequencer_if
//   Command and switch-status bundle for switch_bank_sequencer.
//
// Handshake: a command transfers on a rising clk edge where req_valid and
// req_ready are both 1. req_ch and req_off are sampled on that same edge.
// The requester holds req_valid, req_ch and req_off stable until that edge.
// req_valid while req_ready is 0 has no effect.
//
// Signals:
//   req_valid  requester -> sequencer  command present
//   req_ready  sequencer -> requester  idle, able to accept
//   req_ch     requester -> sequencer  requested channel index
//   req_off    requester -> sequencer  all-off command (req_ch ignored)
//   sw_en      sequencer -> bank       switch drive, at most one bit set
//   active_ch  sequencer -> requester  index of the closed channel
//   active_vld sequencer -> requester  active_ch is closed and settled
//   busy       sequencer -> requester  sequence in progress
//   done       sequencer -> requester  one-cycle completion pulse
//   err        sequencer -> requester  one-cycle invalid-channel pulse
// ---------------------------------------------------------------------------
interface switch_bank_sequencer_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic              req_valid;
    logic              req_ready;
    logic [CH_W-1:0]   req_ch;
    logic              req_off;
    logic [N_CH-1:0]   sw_en;
    logic [CH_W-1:0]   active_ch;
    logic              active_vld;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_ch, req_off,
        input  req_ready, sw_en, active_ch, active_vld, busy, done, err
    );

    modport slave (
        input  req_valid, req_ch, req_off,
        output req_ready, sw_en, active_ch, active_vld, busy, done, err
    );
endinterface

// File: rtl/switch_bank_sequencer.sv
// ---------------------------------------------------------------------------
// switch_bank_sequencer
//   Break-before-make sequencer for a bank of N_CH analog switches/relays.
//   Each accepted command opens every switch for D cycles, then (for a
//   channel select) closes the requested switch and waits S cycles before
//   pulsing done. D = max(DEAD_CYC,1), S = max(SETTLE_CYC,1).
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          switch_bank_sequencer_if.slave (command + status bundle)
//   o_dbg_state  current FSM state (IDLE=0, BREAK=1, MAKE=2, DONE=3)
//
// Configuration macro:
//   SWSEQ_SAME_CH_SKIP_EN  when defined, re-selecting the already closed and
//                          settled channel completes in one cycle without
//                          opening the switch.
// ---------------------------------------------------------------------------
module switch_bank_sequencer #(
    parameter int N_CH       = 4,
    parameter int DEAD_CYC   = 8,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    switch_bank_sequencer_if.slave  bus,
    output logic [1:0]              o_dbg_state
);
    localparam int CH_W   = $clog2(N_CH);
    localparam int D_EFF  = (DEAD_CYC   < 1) ? 1 : DEAD_CYC;
    localparam int S_EFF  = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam logic [CNT_W-1:0] D_LD = CNT_W'(D_EFF);
    localparam logic [CNT_W-1:0] S_LD = CNT_W'(S_EFF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_MAKE  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state,      w_state;
    logic [CNT_W-1:0]  r_cnt,        w_cnt;
    logic [CH_W-1:0]   r_ch,         w_ch;
    logic              r_off,        w_off;
    logic [N_CH-1:0]   r_sw_en,      w_sw_en;
    logic [CH_W-1:0]   r_active_ch,  w_active_ch;
    logic              r_active_vld, w_active_vld;
    logic              r_done,       w_done;
    logic              r_err,        w_err;
    logic              r_ready,      w_ready;
    logic              r_busy,       w_busy;

    logic              w_accept;
    logic              w_ch_ok;
    logic              w_skip;
    logic              w_expire;
    logic [N_CH-1:0]   w_onehot;

    // r_ready is only ever 1 in IDLE, so it alone qualifies acceptance.
    assign w_accept = bus.req_valid && r_ready;
    assign w_ch_ok  = (int'(bus.req_ch) < N_CH);
    assign w_expire = (r_cnt <= CNT_W'(1));
    assign w_onehot = {{(N_CH-1){1'b0}}, 1'b1} << r_ch;

`ifdef SWSEQ_SAME_CH_SKIP_EN
    assign w_skip = !bus.req_off && r_active_vld && (bus.req_ch == r_active_ch);
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_ch         = r_ch;
        w_off        = r_off;
        w_sw_en      = r_sw_en;
        w_active_ch  = r_active_ch;
        w_active_vld = r_active_vld;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_ready      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_accept) begin
                    w_ready = 1'b1;
                end else if (!bus.req_off && !w_ch_ok) begin
                    // Rejected: stay idle, hold ready low for the err cycle.
                    w_err = 1'b1;
                end else if (w_skip) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    w_ch    = bus.req_ch;
                    w_off   = 1'b0;
                end else begin
                    w_state      = S_BREAK;
                    w_ch         = bus.req_ch;
                    w_off        = bus.req_off;
                    w_sw_en      = '0;
                    w_active_vld = 1'b0;
                    w_cnt        = D_LD;
                end
            end
            S_BREAK: begin
                if (!w_expire) begin
                    w_cnt = r_cnt - CNT_W'(1);
                end else if (r_off) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_state     = S_MAKE;
                    w_sw_en     = w_onehot;
                    w_active_ch = r_ch;
                    w_cnt       = S_LD;
                end
            end
            S_MAKE: begin
                if (!w_expire) begin
                    w_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_state      = S_DONE;
                    w_done       = 1'b1;
                    w_active_vld = 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
            end
            default: begin
                w_state      = S_IDLE;
                w_sw_en      = '0;
                w_active_vld = 1'b0;
                w_ready      = 1'b1;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ch         <= '0;
            r_off        <= 1'b0;
            r_sw_en      <= '0;
            r_active_ch  <= '0;
            r_active_vld <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_ch         <= w_ch;
            r_off        <= w_off;
            r_sw_en      <= w_sw_en;
            r_active_ch  <= w_active_ch;
            r_active_vld <= w_active_vld;
            r_done       <= w_done;
            r_err        <= w_err;
            r_ready      <= w_ready;
            r_busy       <= w_busy;
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.sw_en      = r_sw_en;
    assign bus.active_ch  = r_active_ch;
    assign bus.active_vld = r_active_vld;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_switch_bank_sequencer.sv
module tb_switch_bank_sequencer;
  localparam int N_CH   = 6;
  localparam int DEAD   = 8;
  localparam int SETTLE = 16;
  localparam int CH_W   = $clog2(N_CH);
  localparam int EW     = 5 + CH_W + N_CH;
`ifdef SWSEQ_SAME_CH_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_bank_sequencer_if #(.N_CH(N_CH)) bus ();
  logic [1:0] dbg_state;

  switch_bank_sequencer #(
    .N_CH(N_CH), .DEAD_CYC(DEAD), .SETTLE_CYC(SETTLE), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  int cmd_id = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: what is closed / settled after each completed command
  logic              m_vld;
  logic [CH_W-1:0]   m_ach;
  logic [N_CH-1:0]   m_sw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {ready, busy, done, err, active_vld, active_ch, sw_en}
  function automatic logic [EW-1:0] pack(input logic r, input logic b, input logic d,
                                         input logic e, input logic v,
                                         input logic [CH_W-1:0] a, input logic [N_CH-1:0] s);
    return {r, b, d, e, v, a, s};
  endfunction

  function automatic logic [EW-1:0] observed();
    return pack(bus.req_ready, bus.busy, bus.done, bus.err, bus.active_vld,
                bus.active_ch, bus.sw_en);
  endfunction

  // Expected per-cycle outputs for cycles 1..L after the accept edge;
  // the last entry is the first cycle with ready back at 1.
  task automatic build(input int ch, input bit off);
    logic [N_CH-1:0] oh;
    logic [CH_W-1:0] c;
    oh = '0;
    c  = ch[CH_W-1:0];
    if (!off && ch >= N_CH) begin
      exp_q.push_back(pack(0, 0, 0, 1, m_vld, m_ach, m_sw));
      exp_q.push_back(pack(1, 0, 0, 0, m_vld, m_ach, m_sw));
    end else if (SKIP && !off && m_vld && ch == int'(m_ach)) begin
      exp_q.push_back(pack(0, 1, 1, 0, 1, m_ach, m_sw));
      exp_q.push_back(pack(1, 0, 0, 0, 1, m_ach, m_sw));
    end else begin
      for (int k = 1; k <= DEAD; k++) exp_q.push_back(pack(0, 1, 0, 0, 0, m_ach, '0));
      if (off) begin
        exp_q.push_back(pack(0, 1, 1, 0, 0, m_ach, '0));
        exp_q.push_back(pack(1, 0, 0, 0, 0, m_ach, '0));
        m_sw  = '0;
        m_vld = 1'b0;
      end else begin
        oh[ch] = 1'b1;
        for (int k = 1; k <= SETTLE; k++) exp_q.push_back(pack(0, 1, 0, 0, 0, c, oh));
        exp_q.push_back(pack(0, 1, 1, 0, 1, c, oh));
        exp_q.push_back(pack(1, 0, 0, 0, 1, c, oh));
        m_sw  = oh;
        m_vld = 1'b1;
        m_ach = c;
      end
    end
  endtask

  // Called right after a negedge with the DUT idle. rst_at>0 pulls reset
  // during that cycle of the sequence.
  task automatic run_cmd(input int ch, input bit off, input int rst_at);
    logic [EW-1:0] e;
    int k;
    cmd_id++;
    build(ch, off);
    bus.req_valid = 1'b1;
    bus.req_ch    = ch[CH_W-1:0];
    bus.req_off   = off;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      check($sformatf("cmd%0d_cyc%0d", cmd_id, k), 32'(observed()), 32'(e));
      check($sformatf("cmd%0d_cyc%0d_onehot", cmd_id, k), 32'($countones(bus.sw_en) <= 1), 32'd1);
      if (rst_at == k) begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check($sformatf("cmd%0d_midreset", cmd_id), 32'(observed()), 32'(pack(1, 0, 0, 0, 0, '0, '0)));
        exp_q.delete();
        m_sw = '0; m_vld = 1'b0; m_ach = '0;
        return;
      end
      // Traffic while not ready must be ignored; drop valid before ready.
      if (exp_q.size() > 0 && e[EW-1] == 1'b0) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_ch    = CH_W'($urandom_range(0, (1 << CH_W) - 1));
        bus.req_off   = 1'($urandom_range(0, 1));
      end else begin
        bus.req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int ch;
    bit off;
    bus.req_valid = 1'b0;
    bus.req_ch    = '0;
    bus.req_off   = 1'b0;
    m_sw = '0; m_vld = 1'b0; m_ach = '0;

    repeat (3) @(negedge clk);
    check("reset_hold", 32'(observed()), 32'(pack(1, 0, 0, 0, 0, '0, '0)));
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(observed()), 32'(pack(1, 0, 0, 0, 0, '0, '0)));

    run_cmd(2, 0, 0);          // first make
    run_cmd(0, 0, 0);          // break-before-make between channels
    run_cmd(0, 1, 0);          // all-off
    run_cmd(7, 0, 0);          // invalid channel
    run_cmd(6, 0, 0);          // first invalid index
    run_cmd(5, 0, 0);          // highest valid channel
    run_cmd(6, 1, 0);          // all-off ignores req_ch
    run_cmd(1, 0, 0);
    run_cmd(1, 0, 0);          // re-request the active channel
    run_cmd(3, 0, 12);         // reset in the middle of a make
    run_cmd(3, 0, 0);

    for (int i = 0; i < 24; i++) begin
      if (m_vld && $urandom_range(0, 2) == 0) ch = int'(m_ach);
      else ch = int'($urandom_range(0, (1 << CH_W) - 1));
      off = ($urandom_range(0, 4) == 0);
      run_cmd(ch, off, 0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
